// File: rtl/cv32e40s_resp_tracker.sv
// Outstanding-transaction tracker between the core OBI request/response path and the MPU.
// Optional protocol checking is built when CV32E40S_RESP_TRACKER_PROTCHK_EN is defined.
module cv32e40s_resp_tracker #(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_trans_valid_i,
  output logic             core_trans_ready_o,
  input  logic             core_trans_we_i,
  output logic             mpu_trans_valid_o,
  input  logic             mpu_trans_ready_i,
  input  logic             mpu_resp_valid_i,
  output logic             resp_valid_o,
  output logic             resp_we_o,
  output logic             one_txn_pend_n_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             prot_err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic             not_full_s;
  logic             acc_s;
  logic             rsp_s;

  assign not_full_s         = (cnt_q != CNT_FULL);
  assign core_trans_ready_o = mpu_trans_ready_i && not_full_s;
  assign mpu_trans_valid_o  = core_trans_valid_i && not_full_s;
  assign acc_s              = core_trans_valid_i && core_trans_ready_o;
  // A response is only taken when something is outstanding; no same-cycle bypass.
  assign rsp_s              = mpu_resp_valid_i && (cnt_q != {CNT_W{1'b0}});

  assign resp_valid_o     = rsp_s;
  assign resp_we_o        = (cnt_q != {CNT_W{1'b0}}) ? fifo_q[rptr_q] : 1'b0;
  assign one_txn_pend_n_o = (cnt_d == CNT_W'(1));
  assign cnt_o            = cnt_q;

  // Next-state for counter, pointers and attribute FIFO.
  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fifo_d = fifo_q;
    if (acc_s) begin
      fifo_d[wptr_q] = core_trans_we_i;
      wptr_d         = (wptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (rsp_s) begin
      rptr_d = (rptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({acc_s, rsp_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= {CNT_W{1'b0}};
      wptr_q <= {PTR_W{1'b0}};
      rptr_q <= {PTR_W{1'b0}};
      fifo_q <= {DEPTH{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fifo_q <= fifo_d;
    end
  end

`ifdef CV32E40S_RESP_TRACKER_PROTCHK_EN
  logic prot_err_q, prot_err_d;

  assign prot_err_d = prot_err_q || (mpu_resp_valid_i && (cnt_q == {CNT_W{1'b0}}));

  // Sticky flag for responses that arrive with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prot_err_q <= 1'b0;
    end else begin
      prot_err_q <= prot_err_d;
    end
  end

  assign prot_err_o = prot_err_q;
`else
  assign prot_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40s_resp_tracker.sv
// Randomized self-checking bench for cv32e40s_resp_tracker against a queue-based reference model.
module tb_cv32e40s_resp_tracker;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             core_trans_valid_i = 1'b0;
  logic             core_trans_ready_o;
  logic             core_trans_we_i = 1'b0;
  logic             mpu_trans_valid_o;
  logic             mpu_trans_ready_i = 1'b0;
  logic             mpu_resp_valid_i = 1'b0;
  logic             resp_valid_o;
  logic             resp_we_o;
  logic             one_txn_pend_n_o;
  logic [CNT_W-1:0] cnt_o;
  logic             prot_err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: outstanding write attributes in acceptance order.
  bit model_q[$];
  bit model_prot = 1'b0;

  cv32e40s_resp_tracker #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .core_trans_valid_i (core_trans_valid_i),
    .core_trans_ready_o (core_trans_ready_o),
    .core_trans_we_i    (core_trans_we_i),
    .mpu_trans_valid_o  (mpu_trans_valid_o),
    .mpu_trans_ready_i  (mpu_trans_ready_i),
    .mpu_resp_valid_i   (mpu_resp_valid_i),
    .resp_valid_o       (resp_valid_o),
    .resp_we_o          (resp_we_o),
    .one_txn_pend_n_o   (one_txn_pend_n_o),
    .cnt_o              (cnt_o),
    .prot_err_o         (prot_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, advance the model at the rising edge.
  task automatic cycle(input bit v, input bit we, input bit mr, input bit rv);
    int  sz;
    bit  exp_ready, exp_acc, exp_rsp, exp_we;
    @(negedge clk);
    core_trans_valid_i = v;
    core_trans_we_i    = we;
    mpu_trans_ready_i  = mr;
    mpu_resp_valid_i   = rv;
    #1;
    sz        = model_q.size();
    exp_ready = mr && (sz < DEPTH);
    exp_acc   = v && exp_ready;
    exp_rsp   = rv && (sz > 0);
    exp_we    = (sz > 0) ? model_q[0] : 1'b0;
    check("cnt",        int'(cnt_o),              sz);
    check("ready",      int'(core_trans_ready_o), int'(exp_ready));
    check("mpu_valid",  int'(mpu_trans_valid_o),  int'(v && (sz < DEPTH)));
    check("resp_valid", int'(resp_valid_o),       int'(exp_rsp));
    check("resp_we",    int'(resp_we_o),          int'(exp_we));
    check("one_pend",   int'(one_txn_pend_n_o),   int'((sz + int'(exp_acc) - int'(exp_rsp)) == 1));
    check("prot_err",   int'(prot_err_o),         int'(model_prot));
    @(posedge clk);
`ifdef CV32E40S_RESP_TRACKER_PROTCHK_EN
    if (rv && (sz == 0)) model_prot = 1'b1;
`endif
    if (exp_rsp) void'(model_q.pop_front());
    if (exp_acc) model_q.push_back(we);
  endtask

  initial begin
    #12;
    check("reset_cnt",      int'(cnt_o),            0);
    check("reset_resp",     int'(resp_valid_o),     0);
    check("reset_one_pend", int'(one_txn_pend_n_o), 0);
    check("reset_prot",     int'(prot_err_o),       0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read, response two cycles later.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Order tagging W then R, then fill and hold a third request.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Simultaneous push/pop at count 1 with alternating attributes.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'(i % 2), 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // Unexpected response with nothing outstanding, also with a same-cycle accept.
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0));

    // Fill, then reset asynchronously mid-cycle.
    while (model_q.size() < DEPTH) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    @(negedge clk);
    core_trans_valid_i = 1'b0;
    mpu_resp_valid_i   = 1'b0;
    mpu_trans_ready_i  = 1'b1;
    #1;
    check("pre_reset_cnt", int'(cnt_o), DEPTH);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_cnt",   int'(cnt_o),              0);
    check("async_reset_ready", int'(core_trans_ready_o), 1);
    check("async_reset_prot",  int'(prot_err_o),         0);
    mpu_trans_ready_i = 1'b0;
    #1;
    check("async_reset_ready_follow", int'(core_trans_ready_o), 0);
    model_q.delete();
    model_prot = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First response after reset is unexpected and dropped.
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
